// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for axis_rr_arbiter.
// Used by the rotator sub-module and the arbiter top.
package axis_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int unsigned MAX_N  = 16;
    localparam int unsigned MAX_IW = 4;

    // First requester searching upward from last+1, wrapping modulo n.
    // Returns last when nothing is requesting.
    function automatic logic [MAX_IW-1:0] rr_pick(
        input logic [MAX_N-1:0]  req,
        input logic [MAX_IW-1:0] last,
        input int unsigned       n
    );
        logic [MAX_IW-1:0] idx;
        logic              found;
        int unsigned       j;
        idx   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_N; k++) begin
            if (k <= n && !found) begin
                j = (32'(last) + k) % n;
                if (req[j[MAX_IW-1:0]]) begin
                    idx   = j[MAX_IW-1:0];
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_pick_comb.sv
// Combinational round-robin priority rotator.
// Request vector plus last-served pointer in, next index and valid out.
module rr_pick_comb
    import axis_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [MAX_N-1:0]  req_ext;
    logic [MAX_IW-1:0] last_ext;

    // Widen to the function's fixed width and rotate-search.
    always_comb begin
        req_ext            = '0;
        req_ext[N-1:0]     = req;
        last_ext           = '0;
        last_ext[IW-1:0]   = last;
        idx                = IW'(rr_pick(req_ext, last_ext, N));
        valid              = |req;
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-input burst-granular round-robin AXI4-Stream merger.
// Define AXIS_RR_ARBITER_TLAST_EN for packet-granular grants with TLAST.
module axis_rr_arbiter
    import axis_rr_arbiter_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N-1:0]              s_axis_tvalid,
    output logic [N-1:0]              s_axis_tready,
    input  logic [N*DATA_WIDTH-1:0]   s_axis_tdata,
`ifdef AXIS_RR_ARBITER_TLAST_EN
    input  logic [N-1:0]              s_axis_tlast,
    output logic                      m_axis_tlast,
`endif
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [$clog2(N)-1:0]      grant_id,
    output logic                      busy
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          beat;
    logic          rel_a;

    rr_pick_comb #(
        .N (N),
        .IW(IW)
    ) u_pick (
        .req  (s_axis_tvalid),
        .last (last_q),
        .idx  (pick_idx),
        .valid(pick_vld)
    );

    assign grant_id = grant_q;

    // Arbitration state, grant, fairness pointer and beat counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and the pass-through mux of the granted source.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        busy          = 1'b0;
        beat          = 1'b0;
        rel_a         = 1'b0;
`ifdef AXIS_RR_ARBITER_TLAST_EN
        m_axis_tlast  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                busy                   = 1'b1;
                m_axis_tvalid          = s_axis_tvalid[grant_q];
                m_axis_tdata           =
                    s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                s_axis_tready[grant_q] = m_axis_tready;
                beat = s_axis_tvalid[grant_q] & m_axis_tready;
`ifdef AXIS_RR_ARBITER_TLAST_EN
                m_axis_tlast = s_axis_tlast[grant_q];
                rel_a        = s_axis_tlast[grant_q];
`else
                rel_a        = (cnt_q == CNT_LAST);
`endif
                if ((beat && rel_a) || !s_axis_tvalid[grant_q]) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end else if (beat) begin
`ifdef AXIS_RR_ARBITER_TLAST_EN
                    if (cnt_q != {CW{1'b1}}) begin
                        cnt_d = cnt_q + CW'(1);
                    end
`else
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
        endcase
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter (N=4, 8-bit data, BURST=4).
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N-1:0]    s_axis_tvalid;
    logic [N-1:0]    s_axis_tready;
    logic [N*DW-1:0] s_axis_tdata;
    logic [N-1:0]    s_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tlast;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 aclk = ~aclk;

    axis_rr_arbiter #(
        .N         (N),
        .DATA_WIDTH(DW),
        .BURST     (4)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
`ifdef AXIS_RR_ARBITER_TLAST_EN
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tlast (m_axis_tlast),
`endif
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .grant_id     (grant_id),
        .busy         (busy)
    );

`ifndef AXIS_RR_ARBITER_TLAST_EN
    assign m_axis_tlast = 1'b0;
`endif

    logic [N-1:0] en;
    int           len  [N];
    logic [7:0]   base [N];
    int           sent [N];
    logic         rdy;

    logic [7:0]   h_dat [64];
    logic         h_tv  [64];
    logic         h_bz  [64];
    logic         h_tl  [64];
    logic [1:0]   h_gid [64];
    logic [3:0]   h_srdy[64];
    int           cyc;
    logic [7:0]   beats[$];
    logic [7:0]   want[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_beats(input string tag, input logic [7:0] w[$]);
        chk({tag, "_count"}, beats.size(), w.size());
        for (int k = 0; k < w.size(); k++) begin
            chk($sformatf("%s_beat%0d", tag, k),
                (k < beats.size()) ? {24'd0, beats[k]} : 32'h1ff,
                {24'd0, w[k]});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_axis_tvalid[i]       = en[i] && (sent[i] < len[i]);
            s_axis_tdata[i*DW+:DW] = base[i] + 8'(sent[i]);
            s_axis_tlast[i]        = (sent[i] == len[i] - 1);
        end
        m_axis_tready = rdy;
    endtask

    task automatic step();
        @(negedge aclk);
        drive();
        #1;
        if (cyc < 63) cyc++;
        h_dat[cyc]  = m_axis_tdata;
        h_tv[cyc]   = m_axis_tvalid;
        h_bz[cyc]   = busy;
        h_tl[cyc]   = m_axis_tlast;
        h_gid[cyc]  = grant_id;
        h_srdy[cyc] = s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
        for (int i = 0; i < N; i++) begin
            if (s_axis_tvalid[i] && s_axis_tready[i]) sent[i]++;
        end
    endtask

    task automatic start();
        cyc = 0;
        beats.delete();
        want.delete();
        for (int i = 0; i < N; i++) begin
            en[i]   = 1'b0;
            len[i]  = 0;
            base[i] = 8'h00;
            sent[i] = 0;
        end
        rdy = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge aclk);
        aresetn = 1'b0;
        drive();
        #1;
        chk({tag, "_rst_mtvalid"}, m_axis_tvalid, 0);
        chk({tag, "_rst_stready"}, s_axis_tready, 0);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_gid"}, grant_id, 0);
        chk({tag, "_rst_mtdata"}, m_axis_tdata, 0);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0;
        start();
        drive();

        // T1: single source, one full burst.
        do_reset("t1");
        en[0] = 1'b1; len[0] = 4; base[0] = 8'h10;
        for (int k = 0; k < 7; k++) step();
        chk("t1_idle_busy", h_bz[1], 0);
        chk("t1_gid", h_gid[2], 0);
        chk("t1_busy", h_bz[2], 1);
        chk("t1_bubble", h_bz[6], 0);
        want = '{8'h10, 8'h11, 8'h12, 8'h13};
        chk_beats("t1", want);

        // T2: all sources saturated, burst rotation with bubbles.
        start();
        do_reset("t2");
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1; len[i] = 8; base[i] = 8'(i << 4);
        end
        for (int k = 0; k < 25; k++) step();
        chk("t2_bub6", h_bz[6], 0);
        chk("t2_bub11", h_bz[11], 0);
        chk("t2_bub16", h_bz[16], 0);
        chk("t2_bub21", h_bz[21], 0);
        chk("t2_gid7", h_gid[7], 1);
        chk("t2_gid12", h_gid[12], 2);
        chk("t2_gid17", h_gid[17], 3);
        chk("t2_gid22", h_gid[22], 0);
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                want.push_back(8'(((g % 4) << 4) + ((g == 4) ? 4 + k : k)));
            end
        end
        chk_beats("t2", want);

        // T3: back-pressure, ready toggling from the first grant cycle.
        start();
        do_reset("t3");
        en[2] = 1'b1; len[2] = 4; base[2] = 8'h20;
        for (int k = 1; k <= 10; k++) begin
            rdy = (k % 2 == 0);
            step();
        end
        chk("t3_hold_tv", h_tv[3], 1);
        chk("t3_hold_dat", h_dat[3], 8'h21);
        chk("t3_hold_srdy", h_srdy[3], 0);
        chk("t3_next_dat", h_dat[4], 8'h21);
        chk("t3_busy8", h_bz[8], 1);
        chk("t3_free9", h_bz[9], 0);
        want = '{8'h20, 8'h21, 8'h22, 8'h23};
        chk_beats("t3", want);

        // T4: short source drops valid, pending source takes over.
        start();
        do_reset("t4");
        en[1] = 1'b1; len[1] = 2; base[1] = 8'h10;
        en[3] = 1'b1; len[3] = 4; base[3] = 8'h30;
        for (int k = 0; k < 10; k++) step();
        chk("t4_gid2", h_gid[2], 1);
        chk("t4_drop_tv", h_tv[4], 0);
        chk("t4_bubble", h_bz[5], 0);
        chk("t4_gid6", h_gid[6], 3);
        chk("t4_busy6", h_bz[6], 1);
        want = '{8'h10, 8'h11, 8'h30, 8'h31, 8'h32, 8'h33};
        chk_beats("t4", want);

        // T5: asynchronous reset in the middle of a src0 burst.
        start();
        do_reset("t5");
        en[0] = 1'b1; len[0] = 8; base[0] = 8'h00;
        en[1] = 1'b1; len[1] = 8; base[1] = 8'h10;
        for (int k = 0; k < 3; k++) step();
        chk("t5_pre_tv", m_axis_tvalid, 1);
        want = '{8'h00, 8'h01};
        chk_beats("t5_pre", want);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t5_async_mtvalid", m_axis_tvalid, 0);
        chk("t5_async_stready", s_axis_tready, 0);
        chk("t5_async_busy", busy, 0);
        step();
        chk("t5_hold_stready", h_srdy[cyc], 0);
        aresetn = 1'b1;
        cyc = 0;
        beats.delete();
        for (int k = 0; k < 3; k++) step();
        chk("t5_gid", h_gid[1], 0);
        chk("t5_busy", h_bz[1], 1);
        chk("t5_dat", h_dat[1], 8'h02);
        want = '{8'h02, 8'h03, 8'h04};
        chk_beats("t5_post", want);

`ifdef AXIS_RR_ARBITER_TLAST_EN
        // T6: packet longer than BURST held until TLAST.
        start();
        do_reset("t6");
        en[0] = 1'b1; len[0] = 6; base[0] = 8'h00;
        en[1] = 1'b1; len[1] = 4; base[1] = 8'h10;
        for (int k = 0; k < 12; k++) step();
        chk("t6_tl6", h_tl[6], 0);
        chk("t6_tl7", h_tl[7], 1);
        chk("t6_bubble", h_bz[8], 0);
        chk("t6_gid9", h_gid[9], 1);
        want = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                 8'h10, 8'h11, 8'h12, 8'h13};
        chk_beats("t6", want);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N-input round-robin arbiter and multiplexer that merges several AXI4-Stream sources onto one 8-bit AXI4-Stream master port.
- The master port feeds the AXI4-Stream slave VIP agent (signal set TVALID/TREADY/TDATA, no TSTRB/TKEEP/TLAST by default, ARESETN present).
- Grants are burst-granular: a source holds the output for up to BURST beats, then arbitration moves on fairly.
- It sits between traffic generators or DUT stream outputs and the single slave VIP in the test bench.

Parameters:
- N, 4, number of source ports; legal range 2..16.
- DATA_WIDTH, 8, TDATA width in bits; must match the slave VIP data width.
- BURST, 4, maximum beats per grant; legal range 1..256.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  N  per-source TVALID.
- s_axis_tready  out  N  per-source TREADY.
- s_axis_tdata  in  N*DATA_WIDTH  per-source TDATA; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tvalid  out  1  merged TVALID.
- m_axis_tready  in  1  merged TREADY from the slave.
- m_axis_tdata  out  DATA_WIDTH  merged TDATA.
- grant_id  out  $clog2(N)  index of the currently granted source.
- busy  out  1  high while in the GRANT state.

Behaviour:
- Reset values (asynchronous on aresetn low):
  - state = IDLE, grant_id = 0, last pointer = N-1, beat counter = 0.
  - m_axis_tvalid = 0, s_axis_tready = 0, busy = 0.
  - m_axis_tdata is don't-care while m_axis_tvalid is low; drive 0.
- FSM states:
  - IDLE: all s_axis_tready = 0 and m_axis_tvalid = 0. If any s_axis_tvalid is high, select the first requester searching upward from last+1 (mod N). Register it in grant_id, clear the beat counter, go to GRANT. Arbitration latency is exactly 1 cycle from TVALID to grant.
  - GRANT: the output is a combinational pass-through of the granted source g:
    - m_axis_tvalid = s_axis_tvalid[g], m_axis_tdata = s_axis_tdata[g].
    - s_axis_tready[g] = m_axis_tready; all other s_axis_tready = 0.
    - A beat is the handshake m_axis_tvalid & m_axis_tready. The counter increments on each beat.
- Release from GRANT to IDLE, setting last = g, happens on either condition:
  - (a) a beat occurs with counter == BURST-1;
  - (b) s_axis_tvalid[g] is low (source has nothing pending; legal only between beats).
- After release there is one IDLE bubble cycle before the next grant, so the maximum sustained throughput is BURST/(BURST+1).
- Fairness: a continuously requesting source waits at most (N-1)*(BURST+1) cycles of other traffic, given m_axis_tready high.
- Simultaneous events:
  - A beat that coincides with condition (a) is transferred, then the FSM releases.
  - A new request arriving in the release cycle is considered in the following IDLE cycle.
- m_axis_tready low holds the current beat (TVALID/TDATA stable, per AXI). The counter does not advance and the grant never changes mid-beat.
- Reset mid-burst aborts the burst immediately. Sources must not expect completion of an un-handshaken beat.
- Counter width is $clog2(BURST+1); it never wraps, because release occurs at BURST-1.
- BURST = 1 gives pure per-beat round-robin.

Optional Feature:
- Macro: AXIS_RR_ARBITER_TLAST_EN.
- Defined:
  - adds input s_axis_tlast[N] and output m_axis_tlast, muxed like TDATA;
  - release condition (a) becomes "beat with TLAST high", so the grant lasts a whole packet and BURST is ignored for release;
  - condition (b) still applies; the counter saturates and is reported nowhere.
- Undefined: no TLAST ports, and release follows (a)/(b) as above. This matches the slave VIP configured with HAS_TLAST = 0.

Decomposition:
- Package axis_rr_arbiter_pkg:
  - state enum typedef {IDLE, GRANT};
  - a function rr_pick(req, last, N) returning the next index, in the same style as the VIP wrapper packages.
- Sub-module rr_pick_comb: combinational priority rotator, N-bit request plus last pointer in, index and valid out. It is natural to reuse it for other arbiters.

Test Plan:
1. Reset, then s_axis_tvalid = 4'b0001 with data 0x10..0x13 and m_axis_tready = 1. Required: grant_id = 0 on the cycle after tvalid, 4 beats 0x10..0x13 on the master, then busy = 0 for 1 cycle.
2. All 4 sources continuously valid (source i sends 0xi0, 0xi1, ...), BURST = 4, tready = 1. Required: output order is 4 beats from src0, then src1, src2, src3, src0, with a 1-cycle bubble between grants.
3. Src2 only, with m_axis_tready toggling 1,0,1,0. Required: the held beat's TDATA stays stable while tready = 0, the counter advances only on handshakes, and 4 beats complete in 8 cycles.
4. Src1 sends 2 beats then drops tvalid while src3 is pending. Required: release after beat 2, grant_id = 3 two cycles later, and no beat is lost or duplicated.
5. Assert aresetn low mid-burst (after beat 2 of src0). Required: m_axis_tvalid and all s_axis_tready go to 0 asynchronously; after release the first grant goes to src0 (last reset to N-1).
6. With AXIS_RR_ARBITER_TLAST_EN: src0 sends a 6-beat packet with TLAST on beat 6, src1 pending. Required: all 6 beats come from src0 despite BURST = 4, m_axis_tlast = 1 on beat 6, then src1 is granted.
